hazard_ctl: RTL and testbench

HAZARD_CTL -- requirements
Module: hazard_ctl

---
 rtl/mips789_defs.sv | 14 +
 rtl/hazard_ctl_if.sv | 11 +
 rtl/hazard_ctl_md_counter.sv | 21 ++
 rtl/hazard_ctl.sv | 56 +++++
 tb/tb_hazard_ctl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mips789_defs.sv
// mips789_defs: shared pipeline codes, hazard FSM states and the HAZARD_MULDIV_STALL_EN default
package mips789_defs;
  typedef enum logic [1:0] {FW_NONE = 2'b00, FW_EX = 2'b01, FW_MEM = 2'b10, FW_WB = 2'b11} fw_sel_e;
  typedef enum logic [1:0] {HZ_IDLE = 2'b00, HZ_LD_STALL = 2'b01, HZ_MD_RUN = 2'b10, HZ_MD_HOLD = 2'b11} hz_state_e;
  localparam int MD_CNT_W = 6;
`ifdef HAZARD_MULDIV_STALL_EN
  localparam bit MD_STALL_EN = 1'b1;
`else
  localparam bit MD_STALL_EN = 1'b0;
`endif
  function automatic logic src_hit(input logic [4:0] wr_rn, input logic [4:0] src, input logic use_src);
    return use_src && wr_rn != 5'd0 && wr_rn == src;
  endfunction
endpackage

// File: rtl/hazard_ctl_if.sv
// hazard_ctl_if: pipeline-side signals of the hazard controller
interface hazard_ctl_if;
  logic [4:0]  id_rs, id_rt, ex_wr_rn;
  logic        id_use_rs, id_use_rt, ex_load, ex_we, md_start, id_rd_hilo, mem_wait;
  logic        pause, id_bubble, md_busy;
  logic [15:0] stall_cnt;
  modport master (output id_rs, id_rt, ex_wr_rn, id_use_rs, id_use_rt, ex_load, ex_we, md_start, id_rd_hilo, mem_wait,
                  input pause, id_bubble, md_busy, stall_cnt);
  modport slave (input id_rs, id_rt, ex_wr_rn, id_use_rs, id_use_rt, ex_load, ex_we, md_start, id_rd_hilo, mem_wait,
                 output pause, id_bubble, md_busy, stall_cnt);
endinterface

// File: rtl/hazard_ctl_md_counter.sv
// hz_md_counter: mul/div latency counter with load, free-running decrement and zero detect
module hz_md_counter
  import mips789_defs::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_busy,
  output logic o_last
);
  logic [MD_CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= MD_CNT_W'(MD_CYCLES - 1);
    else if (r_cnt != '0) r_cnt <= r_cnt - MD_CNT_W'(1);
  assign o_busy = r_cnt != '0;
  // last busy cycle: the FSM leaves its mul/div state on the same edge the count hits zero
  assign o_last = r_cnt <= MD_CNT_W'(1);
endmodule

// File: rtl/hazard_ctl.sv
// hazard_ctl: load-use / mul-div stall control with stall counter; mul/div stalls enabled by HAZARD_MULDIV_STALL_EN
module hazard_ctl
  import mips789_defs::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  hazard_ctl_if.slave hz
);
  hz_state_e   r_state;
  logic [15:0] r_stall_cnt;
  logic        w_load_hit, w_pause, w_md_load, w_md_busy, w_md_last;
  assign w_load_hit = hz.ex_load && hz.ex_we &&
                      (src_hit(hz.ex_wr_rn, hz.id_rs, hz.id_use_rs) || src_hit(hz.ex_wr_rn, hz.id_rt, hz.id_use_rt));
`ifdef HAZARD_MULDIV_STALL_EN
  // an issue only counts when ID really advances; load_hit beats md_start, last issue wins
  assign w_md_load = hz.md_start && !hz.mem_wait &&
                     ((r_state == HZ_IDLE && !w_load_hit) || r_state == HZ_LD_STALL ||
                      (r_state == HZ_MD_RUN && !hz.id_rd_hilo));
  hz_md_counter #(.MD_CYCLES(MD_CYCLES)) u_md_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_load(w_md_load),
    .o_busy(w_md_busy),
    .o_last(w_md_last)
  );
`else
  logic w_unused_md;
  assign w_unused_md = hz.md_start;
  assign w_md_load   = 1'b0;
  assign w_md_busy   = 1'b0;
  assign w_md_last   = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= HZ_IDLE;
      r_stall_cnt <= '0;
    end else begin
      if (!hz.mem_wait)
        case (r_state)
          HZ_IDLE:     r_state <= w_load_hit ? HZ_LD_STALL : w_md_load ? HZ_MD_RUN : HZ_IDLE;
          HZ_LD_STALL: r_state <= (w_md_load || w_md_busy) ? HZ_MD_RUN : HZ_IDLE;
          HZ_MD_RUN:   r_state <= w_md_load ? HZ_MD_RUN : w_md_last ? HZ_IDLE : hz.id_rd_hilo ? HZ_MD_HOLD : HZ_MD_RUN;
          default:     r_state <= w_md_last ? HZ_IDLE : HZ_MD_HOLD;
        endcase
      if (w_pause && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  // rst_n gating keeps pause low while reset is held, even with mem_wait high
  assign w_pause = rst_n && (hz.mem_wait || (r_state == HZ_IDLE && w_load_hit) ||
                             r_state == HZ_MD_HOLD || (hz.id_rd_hilo && w_md_busy));
  assign hz.pause     = w_pause;
  assign hz.id_bubble = w_pause && !hz.mem_wait;
  assign hz.md_busy   = MD_STALL_EN && w_md_busy;
  assign hz.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_hazard_ctl.sv
// tb_hazard_ctl: directed scoreboard bench for hazard_ctl
module tb_hazard_ctl;
  import mips789_defs::*;
  localparam int MDC = 32;
  typedef enum {S_PAUSE, S_BUB, S_BUSY, S_CNT, S_STATE} sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [15:0] exp;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int   n_asrt = 0, n_fail = 0, sc = 0;
  exp_t sbq[$];
  hazard_ctl_if hz();
  hazard_ctl #(.MD_CYCLES(MDC)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));
  always #5 clk = ~clk;
  function automatic logic [15:0] obs(sel_e s);
    case (s)
      S_PAUSE: return {15'd0, hz.pause};
      S_BUB:   return {15'd0, hz.id_bubble};
      S_BUSY:  return {15'd0, hz.md_busy};
      S_CNT:   return hz.stall_cnt;
      default: return {14'd0, dut.r_state};
    endcase
  endfunction
  task automatic ex(input string tag, input sel_e s, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.exp = v;
    sbq.push_back(e);
  endtask
  task automatic tick();
    exp_t e;
    logic [15:0] o;
    #2;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = obs(e.sel);
      n_asrt++;
      assert (o === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.exp);
      end
    end
    @(negedge clk);
  endtask
  task automatic tk(input string tag, input logic p, input logic b, input hz_state_e st);
    ex({tag, "_pause"}, S_PAUSE, {15'd0, p});
    ex({tag, "_bubble"}, S_BUB, {15'd0, b});
    ex({tag, "_state"}, S_STATE, {14'd0, st});
    ex({tag, "_cnt"}, S_CNT, 16'(sc));
    if (p) sc++;
    tick();
  endtask
  task automatic idle_in();
    hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.ex_wr_rn = 5'd0;
    hz.id_use_rs = 1'b0; hz.id_use_rt = 1'b0; hz.ex_load = 1'b0; hz.ex_we = 1'b0;
    hz.md_start = 1'b0; hz.id_rd_hilo = 1'b0; hz.mem_wait = 1'b0;
  endtask
  task automatic ld(input logic [4:0] wr, input logic [4:0] rs, input logic urs,
                    input logic [4:0] rt, input logic urt, input logic l, input logic we);
    hz.ex_wr_rn = wr; hz.id_rs = rs; hz.id_use_rs = urs; hz.id_rt = rt; hz.id_use_rt = urt;
    hz.ex_load = l; hz.ex_we = we;
  endtask
  initial begin
    rst_n = 1'b0;
    idle_in();
    hz.mem_wait = 1'b1;
    repeat (2) @(negedge clk);
    ex("rst_pause", S_PAUSE, 16'd0);
    ex("rst_bubble", S_BUB, 16'd0);
    ex("rst_busy", S_BUSY, 16'd0);
    ex("rst_cnt", S_CNT, 16'd0);
    ex("rst_state", S_STATE, 16'(HZ_IDLE));
    tick();
    hz.mem_wait = 1'b0;
    rst_n = 1'b1;
    sc = 0;
    tk("idle", 0, 0, HZ_IDLE);
    ld(5'd5, 5'd5, 1, 5'd0, 0, 1, 1);
    tk("lu_rs_hit", 1, 1, HZ_IDLE);
    idle_in();
    tk("lu_rs_stall", 0, 0, HZ_LD_STALL);
    tk("lu_rs_back", 0, 0, HZ_IDLE);
    ld(5'd7, 5'd7, 0, 5'd7, 1, 1, 1);
    tk("lu_rt_hit", 1, 1, HZ_IDLE);
    idle_in();
    tk("lu_rt_stall", 0, 0, HZ_LD_STALL);
    tk("lu_rt_back", 0, 0, HZ_IDLE);
    ld(5'd9, 5'd9, 0, 5'd9, 0, 1, 1);
    tk("no_use", 0, 0, HZ_IDLE);
    ld(5'd5, 5'd5, 1, 5'd5, 1, 1, 0);
    tk("no_we", 0, 0, HZ_IDLE);
    ld(5'd5, 5'd5, 1, 5'd5, 1, 0, 1);
    tk("no_load", 0, 0, HZ_IDLE);
    ld(5'd6, 5'd5, 1, 5'd4, 1, 1, 1);
    tk("no_match", 0, 0, HZ_IDLE);
    ld(5'd0, 5'd0, 1, 5'd0, 0, 1, 1);
    tk("ld_r0", 0, 0, HZ_IDLE);
    tk("ld_r0_hold", 0, 0, HZ_IDLE);
    idle_in();
    hz.mem_wait = 1'b1;
    tk("mw_idle", 1, 0, HZ_IDLE);
    hz.mem_wait = 1'b0;
    ld(5'd12, 5'd12, 1, 5'd0, 0, 1, 1);
    tk("mw_ld_hit", 1, 1, HZ_IDLE);
    idle_in();
    hz.mem_wait = 1'b1;
    repeat (4) tk("mw_ld_frozen", 1, 0, HZ_LD_STALL);
    hz.mem_wait = 1'b0;
    tk("mw_ld_release", 0, 0, HZ_LD_STALL);
    tk("mw_ld_back", 0, 0, HZ_IDLE);
    ld(5'd3, 5'd3, 1, 5'd0, 0, 1, 1);
    hz.md_start = 1'b1;
    tk("ldmd_hit", 1, 1, HZ_IDLE);
    ld(5'd0, 5'd0, 0, 5'd0, 0, 0, 0);
    tk("ldmd_stall", 0, 0, HZ_LD_STALL);
    hz.md_start = 1'b0;
`ifdef HAZARD_MULDIV_STALL_EN
    ex("ldmd_busy", S_BUSY, 16'd1);
    tk("ldmd_run", 0, 0, HZ_MD_RUN);
    tk("ldmd_run2", 0, 0, HZ_MD_RUN);
    rst_n = 1'b0;
    ex("md_rst_busy", S_BUSY, 16'd0);
    ex("md_rst_state", S_STATE, 16'(HZ_IDLE));
    ex("md_rst_cnt", S_CNT, 16'd0);
    tick();
    rst_n = 1'b1;
    sc = 0;
    ex("md_rst_after", S_BUSY, 16'd0);
    tk("md_rst_after", 0, 0, HZ_IDLE);
    hz.md_start = 1'b1;
    ex("md_issue_busy", S_BUSY, 16'd0);
    tk("md_issue", 0, 0, HZ_IDLE);
    hz.md_start = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      ex("md_early_busy", S_BUSY, 16'd1);
      tk("md_early", 0, 0, HZ_MD_RUN);
    end
    hz.id_rd_hilo = 1'b1;
    for (int c = 3; c < MDC; c++) begin
      ex("md_hilo_busy", S_BUSY, 16'd1);
      tk("md_hilo_wait", 1, 1, c == 3 ? HZ_MD_RUN : HZ_MD_HOLD);
    end
    ex("md_done_busy", S_BUSY, 16'd0);
    tk("md_hilo_done", 0, 0, HZ_IDLE);
    tk("md_hilo_idle", 0, 0, HZ_IDLE);
    hz.id_rd_hilo = 1'b0;
    hz.md_start = 1'b1;
    tk("rs_issue", 0, 0, HZ_IDLE);
    hz.md_start = 1'b0;
    repeat (4) tk("rs_run", 0, 0, HZ_MD_RUN);
    hz.md_start = 1'b1;
    tk("rs_reissue", 0, 0, HZ_MD_RUN);
    hz.md_start = 1'b0;
    for (int c = 1; c < MDC; c++) begin
      ex("rs_busy", S_BUSY, 16'd1);
      tk("rs_after", 0, 0, HZ_MD_RUN);
    end
    ex("rs_done_busy", S_BUSY, 16'd0);
    tk("rs_done", 0, 0, HZ_IDLE);
`else
    ex("ldmd_busy", S_BUSY, 16'd0);
    tk("ldmd_back", 0, 0, HZ_IDLE);
    hz.md_start = 1'b1;
    hz.id_rd_hilo = 1'b1;
    repeat (3) begin
      ex("md_off_busy", S_BUSY, 16'd0);
      tk("md_off", 0, 0, HZ_IDLE);
    end
    idle_in();
`endif
    ld(5'd20, 5'd0, 0, 5'd20, 1, 1, 1);
    tk("rst_ld_hit", 1, 1, HZ_IDLE);
    idle_in();
    hz.mem_wait = 1'b1;
    tk("rst_ld_frozen", 1, 0, HZ_LD_STALL);
    rst_n = 1'b0;
    ex("rst_mid_pause", S_PAUSE, 16'd0);
    ex("rst_mid_bubble", S_BUB, 16'd0);
    ex("rst_mid_busy", S_BUSY, 16'd0);
    ex("rst_mid_state", S_STATE, 16'(HZ_IDLE));
    ex("rst_mid_cnt", S_CNT, 16'd0);
    tick();
    rst_n = 1'b1;
    sc = 0;
    repeat (70000) @(negedge clk);
    ex("sat_cnt", S_CNT, 16'hFFFF);
    ex("sat_pause", S_PAUSE, 16'd1);
    tick();
    ex("sat_hold", S_CNT, 16'hFFFF);
    tick();
    hz.mem_wait = 1'b0;
    ex("sat_end_pause", S_PAUSE, 16'd0);
    ex("sat_end_cnt", S_CNT, 16'hFFFF);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
